segasys1_rom_arbiter: RTL
=========================

Name: segasys1_rom_arbiter

Overview:
Shares one 32-bit external ROM memory port between the four System 1 ROM fetch channels: main CPU, sound CPU, tile and sprite. Each channel presents an address and sees a held data register plus a ready flag. The arbiter detects stale channels, issues one memory transaction at a time by fixed priority, and steers the returned word or byte into the channel register. It sits between the SEGASYSTEM1 ROM address/data ports and the SDRAM/BRAM controller.

Parameters:
CPU_BASE, 24'h000000, byte base of CPU ROM region (4-byte aligned)
SND_BASE, 24'h020000, byte base of sound ROM region (4-byte aligned)
TILE_BASE, 24'h028000, byte base of tile ROM region (4-byte aligned)
SPR_BASE, 24'h048000, byte base of sprite ROM region (4-byte aligned)

Ports:
clk40M  in  1  system clock
reset  in  1  asynchronous, active-high reset
ROMCL  in  1  ROM download in progress; no fetch is issued while high
cpu_rom_addr  in  17  CPU byte address
cpu_rom_do  out  8  CPU data
cpu_rom_ok  out  1  cpu_rom_do matches cpu_rom_addr
snd_rom_addr  in  15  sound byte address
snd_rom_do  out  8  sound data
snd_rom_ok  out  1  sound data valid for current address
tile_rom_addr  in  15  tile 32-bit word index
tile_rom_do  out  32  tile data
tile_rom_ok  out  1  tile data valid
spr_rom_addr  in  18  sprite byte address
spr_rom_do  out  8  sprite data
spr_rom_ok  out  1  sprite data valid
mem_req  out  1  request; held high with stable mem_addr until mem_ack
mem_addr  out  22  32-bit word address
mem_ack  in  1  one-cycle pulse; mem_dout valid in the same cycle
mem_dout  in  32  read data, little-endian byte lanes

Behaviour:
- Reset (async): state IDLE; mem_req=0, mem_addr=0; all *_do=0; all valid bits=0, so every *_ok=0.
- Per channel: registers last_addr, data, valid. pending = !valid || addr != last_addr (combinational). *_ok = !pending.
- Priority, fixed: tile > sprite > cpu > sound.
- IDLE: if !ROMCL and any pending, latch the highest-priority channel as grant and latch its address; next cycle enter BUSY with mem_req=1. Otherwise stay in IDLE.
- Word address calculation:
  - Byte channels: mem_addr = (BASE + zero-extended addr)[23:2]; lane = addr[1:0].
  - Tile: mem_addr = TILE_BASE[23:2] + addr.
  - Sums are 24-bit and wrap modulo 2^24 with no error.
- BUSY: mem_req stays 1 and mem_addr stays constant until mem_ack.
  - On mem_ack, the granted channel takes data = mem_dout (tile) or mem_dout[8*lane+7 -: 8] (byte channels), last_addr = latched address, valid=1.
  - On the same edge, mem_req drops and the state returns to IDLE.
- Latency: a channel whose address changes while the arbiter is IDLE with no other request gets mem_req on the next edge. With mem_ack N cycles after the request, *_ok rises at edge+N+1.
- Throughput: at most one transaction per (ack latency + 1) cycles; IDLE always inserts one cycle.
- Address change during BUSY: the fetch completes and is stored against the old latched address. The channel stays pending and is refetched later; stale data is never flagged ok.
- ROMCL rising while BUSY: the current transaction completes. No new grant is made while ROMCL=1. ROMCL falling does not invalidate data; the download owner must pulse reset if ROM contents changed.
- mem_ack while IDLE: ignored.
- Reset while BUSY: mem_req drops immediately. The memory controller must tolerate an abandoned request.
- Starvation: lower channels can starve under continuous higher-priority misses. This is accepted because video addresses dwell for at least 4 cycles at 40 MHz.

Decomposition:
- Package segasys1_rom_pkg: channel index constants (CH_TILE=0, CH_SPR=1, CH_CPU=2, CH_SND=3), state encoding (ST_IDLE, ST_BUSY), default base constants.
- Sub-module segasys1_rom_chan, parameterised on address width and data width (8/32). It holds last_addr/data/valid, computes pending, and captures data on a load strobe with lane select. Instantiated 4x.
- The arbiter FSM and address mux live in the top.

Test Plan:
1. Reset, then all addresses 0 with mem_ack tied low:
   - All *_ok=0 and *_do=0.
   - mem_req=1 on the 2nd edge with mem_addr=TILE_BASE>>2=0x00A000.
2. Single CPU miss: cpu_rom_addr=17'h00005, other channels valid, ack 3 cycles after req with mem_dout=32'hDDCCBBAA.
   - mem_addr=0x000001.
   - cpu_rom_do=8'hBB and cpu_rom_ok=1 one edge after ack.
3. Simultaneous tile (0x0010) and sound (0x0003) misses:
   - Tile is served first (mem_addr=0x00A010).
   - Sound follows after one IDLE cycle (mem_addr=0x008000, lane 3).
4. ROMCL=1 with CPU pending:
   - No mem_req for 100 cycles.
   - After ROMCL falls, mem_req rises on the next edge.
5. cpu_rom_addr changes 4→8 during BUSY:
   - The first ack stores data against address 4 and cpu_rom_ok stays 0.
   - A second request with mem_addr=0x000002 follows; ok=1 after its ack.
6. Reset asserted mid-BUSY:
   - mem_req=0 and all ok=0 asynchronously.
   - After release, refetch starts with tile.

Source files
------------

// File: rtl/segasys1_rom_pkg.sv
// Shared constants for the System 1 ROM arbiter: channel indices, FSM states,
// default region bases and the byte-to-word address helper.
package segasys1_rom_pkg;

    localparam int CH_TILE = 0;
    localparam int CH_SPR  = 1;
    localparam int CH_CPU  = 2;
    localparam int CH_SND  = 3;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } arb_state_t;

    localparam logic [23:0] DEF_CPU_BASE  = 24'h000000;
    localparam logic [23:0] DEF_SND_BASE  = 24'h020000;
    localparam logic [23:0] DEF_TILE_BASE = 24'h028000;
    localparam logic [23:0] DEF_SPR_BASE  = 24'h048000;

    // Byte address inside a region -> 32-bit word address, wrapping at 2^24.
    function automatic logic [21:0] byte_word_addr(input logic [23:0] base,
                                                   input logic [17:0] addr);
        logic [23:0] sum;
        sum = base + {6'd0, addr};
        return sum[23:2];
    endfunction

endpackage

// File: rtl/segasys1_rom_chan.sv
// One ROM fetch channel: holds the last fetched address/data and flags
// itself pending whenever the requested address differs or nothing is held.
module segasys1_rom_chan
    import segasys1_rom_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic [1:0]    lane,
    input  logic [31:0]   mem_dout,
    output logic [DW-1:0] data,
    output logic          pending
);

    logic [AW-1:0] last_addr;
    logic          valid;
    logic [31:0]   shifted;

    // Byte channels pick their lane; the word channel takes the whole word.
    assign shifted = (DW == 32) ? mem_dout : (mem_dout >> {lane, 3'b000});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_addr <= '0;
            data      <= '0;
            valid     <= 1'b0;
        end else if (load) begin
            last_addr <= load_addr;
            data      <= shifted[DW-1:0];
            valid     <= 1'b1;
        end
    end

    assign pending = !valid || (addr != last_addr);

endmodule

// File: rtl/segasys1_rom_arbiter.sv
// Shares one 32-bit ROM port between tile, sprite, CPU and sound fetch
// channels with fixed priority, one outstanding transaction at a time.
module segasys1_rom_arbiter
    import segasys1_rom_pkg::*;
#(
    parameter logic [23:0] CPU_BASE  = DEF_CPU_BASE,
    parameter logic [23:0] SND_BASE  = DEF_SND_BASE,
    parameter logic [23:0] TILE_BASE = DEF_TILE_BASE,
    parameter logic [23:0] SPR_BASE  = DEF_SPR_BASE
) (
    input  logic        clk40M,
    input  logic        reset,
    input  logic        ROMCL,
    input  logic [16:0] cpu_rom_addr,
    output logic [7:0]  cpu_rom_do,
    output logic        cpu_rom_ok,
    input  logic [14:0] snd_rom_addr,
    output logic [7:0]  snd_rom_do,
    output logic        snd_rom_ok,
    input  logic [14:0] tile_rom_addr,
    output logic [31:0] tile_rom_do,
    output logic        tile_rom_ok,
    input  logic [17:0] spr_rom_addr,
    output logic [7:0]  spr_rom_do,
    output logic        spr_rom_ok,
    output logic        mem_req,
    output logic [21:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_dout
);

    arb_state_t  state;
    logic [3:0]  pending;
    logic [3:0]  load;
    logic [1:0]  grant;
    logic [17:0] lat_addr;

    logic        sel_any;
    logic [1:0]  sel_ch;
    logic [17:0] sel_addr;
    logic [21:0] sel_word;

    // Fixed-priority pick among stale channels: tile > sprite > cpu > sound.
    always_comb begin
        sel_any  = 1'b0;
        sel_ch   = 2'(CH_TILE);
        sel_addr = '0;
        sel_word = '0;
        if (pending[CH_TILE]) begin
            sel_any  = 1'b1;
            sel_ch   = 2'(CH_TILE);
            sel_addr = {3'd0, tile_rom_addr};
            sel_word = TILE_BASE[23:2] + {7'd0, tile_rom_addr};
        end else if (pending[CH_SPR]) begin
            sel_any  = 1'b1;
            sel_ch   = 2'(CH_SPR);
            sel_addr = spr_rom_addr;
            sel_word = byte_word_addr(SPR_BASE, spr_rom_addr);
        end else if (pending[CH_CPU]) begin
            sel_any  = 1'b1;
            sel_ch   = 2'(CH_CPU);
            sel_addr = {1'b0, cpu_rom_addr};
            sel_word = byte_word_addr(CPU_BASE, {1'b0, cpu_rom_addr});
        end else if (pending[CH_SND]) begin
            sel_any  = 1'b1;
            sel_ch   = 2'(CH_SND);
            sel_addr = {3'd0, snd_rom_addr};
            sel_word = byte_word_addr(SND_BASE, {3'd0, snd_rom_addr});
        end
    end

    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            grant    <= '0;
            lat_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!ROMCL && sel_any) begin
                        state    <= ST_BUSY;
                        mem_req  <= 1'b1;
                        mem_addr <= sel_word;
                        grant    <= sel_ch;
                        lat_addr <= sel_addr;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        load = '0;
        if (state == ST_BUSY && mem_ack) load[grant] = 1'b1;
    end

    segasys1_rom_chan #(.AW(15), .DW(32)) u_tile (
        .clk(clk40M), .reset(reset), .addr(tile_rom_addr), .load(load[CH_TILE]),
        .load_addr(lat_addr[14:0]), .lane(lat_addr[1:0]), .mem_dout(mem_dout),
        .data(tile_rom_do), .pending(pending[CH_TILE])
    );

    segasys1_rom_chan #(.AW(18), .DW(8)) u_spr (
        .clk(clk40M), .reset(reset), .addr(spr_rom_addr), .load(load[CH_SPR]),
        .load_addr(lat_addr), .lane(lat_addr[1:0]), .mem_dout(mem_dout),
        .data(spr_rom_do), .pending(pending[CH_SPR])
    );

    segasys1_rom_chan #(.AW(17), .DW(8)) u_cpu (
        .clk(clk40M), .reset(reset), .addr(cpu_rom_addr), .load(load[CH_CPU]),
        .load_addr(lat_addr[16:0]), .lane(lat_addr[1:0]), .mem_dout(mem_dout),
        .data(cpu_rom_do), .pending(pending[CH_CPU])
    );

    segasys1_rom_chan #(.AW(15), .DW(8)) u_snd (
        .clk(clk40M), .reset(reset), .addr(snd_rom_addr), .load(load[CH_SND]),
        .load_addr(lat_addr[14:0]), .lane(lat_addr[1:0]), .mem_dout(mem_dout),
        .data(snd_rom_do), .pending(pending[CH_SND])
    );

    assign tile_rom_ok = !pending[CH_TILE];
    assign spr_rom_ok  = !pending[CH_SPR];
    assign cpu_rom_ok  = !pending[CH_CPU];
    assign snd_rom_ok  = !pending[CH_SND];

endmodule
